// File: rtl/mac_array_fix_if.sv
// mac_array_fix_if -- handshake bus of the mac_array_fix MAC engine.
//
// Signals (lane i occupies bits [i*W +: W] of x, c and o):
//   in_valid / in_ready / in_last  input beat handshake, in_last ends a vector
//   x, c                           per-lane operand and coefficient, Q(W-F).F
//   o_valid / o_ready              result handshake, o_valid held until taken
//   o, o_sat                       per-lane saturated result and clip flag
//
// Modports: master drives beats and consumes results, slave is the engine.
interface mac_array_fix_if #(
    parameter int W = 16,
    parameter int N = 4
);
    logic           in_valid;
    logic           in_ready;
    logic           in_last;
    logic [N*W-1:0] x;
    logic [N*W-1:0] c;
    logic           o_valid;
    logic           o_ready;
    logic [N*W-1:0] o;
    logic [N-1:0]   o_sat;

    modport master (
        output in_valid, in_last, x, c, o_ready,
        input  in_ready, o_valid, o, o_sat
    );

    modport slave (
        input  in_valid, in_last, x, c, o_ready,
        output in_ready, o_valid, o, o_sat
    );
endinterface

// File: rtl/mac_array_fix.sv
// mac_array_fix -- N-lane signed fixed-point multiply-accumulate engine.
//
// Each lane accumulates x*c over a vector of beats in a 2W+G bit wrapping
// accumulator. On the last beat the sum is rounded half toward +inf, shifted
// back by F fraction bits and saturated to W bits into the result register.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset (clears accumulators and result)
//   clr    synchronous accumulator flush; result register untouched, any
//          beat accepted in the same cycle is dropped
//   bus    mac_array_fix_if.slave: input beats and result handshake
//
// Build option: define MAC_ARRAY_FIX_RELU_EN to clamp negative lane results
// to zero after saturation; o_sat then flags only the upper clip.
module mac_array_fix #(
    parameter int W = 16,
    parameter int F = 8,
    parameter int N = 4,
    parameter int G = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    mac_array_fix_if.slave   bus
);
    localparam int AW = 2*W + G;

    // Rounding constant 2^(F-1); zero when there are no fraction bits.
    localparam logic signed [AW:0] RND  = (F > 0) ? ((AW+1)'(1) << ((F > 0) ? F-1 : 0)) : '0;
    localparam logic signed [AW:0] MAXV = {{(AW-W+2){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [AW:0] MINV = {{(AW-W+2){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic {ACCUM, HOLD} state_e;

    state_e                state_q, state_d;
    logic signed [AW-1:0]  acc_q [N];
    logic signed [AW-1:0]  acc_d [N];
    logic [N*W-1:0]        o_q, o_d;
    logic [N-1:0]          sat_q, sat_d;

    logic signed [AW-1:0]  sum_w [N];
    logic [N*W-1:0]        res_w;
    logic [N-1:0]          rsat_w;

    logic signed [W-1:0]   xl, cl;
    logic signed [2*W-1:0] prod;
    logic signed [AW:0]    rnd, shf;
    logic                  fire, take;

    assign bus.o_valid  = (state_q == HOLD);
    assign bus.in_ready = !bus.o_valid || bus.o_ready;
    assign bus.o        = o_q;
    assign bus.o_sat    = sat_q;

    // Lane datapath: multiply, accumulate, round, saturate.
    always_comb begin
        xl     = '0;
        cl     = '0;
        prod   = '0;
        rnd    = '0;
        shf    = '0;
        res_w  = '0;
        rsat_w = '0;
        for (int unsigned i = 0; i < N; i++) begin
            xl       = bus.x[i*W +: W];
            cl       = bus.c[i*W +: W];
            prod     = xl * cl;
            sum_w[i] = acc_q[i] + {{G{prod[2*W-1]}}, prod};
            // One extra bit keeps the rounding add from wrapping the sum.
            rnd      = {sum_w[i][AW-1], sum_w[i]} + RND;
            shf      = rnd >>> F;
`ifdef MAC_ARRAY_FIX_RELU_EN
            if (shf > MAXV) begin
                res_w[i*W +: W] = {1'b0, {(W-1){1'b1}}};
                rsat_w[i]       = 1'b1;
            end else if (shf < 0) begin
                res_w[i*W +: W] = '0;
            end else begin
                res_w[i*W +: W] = shf[W-1:0];
            end
`else
            if (shf > MAXV) begin
                res_w[i*W +: W] = {1'b0, {(W-1){1'b1}}};
                rsat_w[i]       = 1'b1;
            end else if (shf < MINV) begin
                res_w[i*W +: W] = {1'b1, {(W-1){1'b0}}};
                rsat_w[i]       = 1'b1;
            end else begin
                res_w[i*W +: W] = shf[W-1:0];
            end
`endif
        end
    end

    // Control and next-state selection.
    always_comb begin
        fire    = bus.in_valid && bus.in_ready;
        take    = bus.o_valid && bus.o_ready;
        state_d = state_q;
        o_d     = o_q;
        sat_d   = sat_q;
        for (int unsigned i = 0; i < N; i++) begin
            acc_d[i] = acc_q[i];
        end

        if (clr) begin
            for (int unsigned i = 0; i < N; i++) begin
                acc_d[i] = '0;
            end
        end else if (fire) begin
            for (int unsigned i = 0; i < N; i++) begin
                acc_d[i] = bus.in_last ? '0 : sum_w[i];
            end
            if (bus.in_last) begin
                o_d   = res_w;
                sat_d = rsat_w;
            end
        end

        // A load wins over a take, so back-to-back results never bubble.
        if (fire && bus.in_last && !clr) begin
            state_d = HOLD;
        end else if (take) begin
            state_d = ACCUM;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            o_q     <= '0;
            sat_q   <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            o_q     <= o_d;
            sat_q   <= sat_d;
            for (int unsigned i = 0; i < N; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end
endmodule

// File: tb/tb_mac_array_fix.sv
// tb_mac_array_fix -- directed self-checking bench for mac_array_fix
// (W=16, F=8, N=4, G=8). Expected values are hand-computed Q8.8 results.
module tb_mac_array_fix;
    logic clk = 1'b0;
    logic rst_n;
    logic clr;
    int   total = 0;
    int   bad   = 0;

    mac_array_fix_if #(.W(16), .N(4)) bus ();

    mac_array_fix #(.W(16), .F(8), .N(4), .G(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus)
    );

    always #5 clk = ~clk;

`ifdef MAC_ARRAY_FIX_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    function automatic logic [63:0] pk(input logic [15:0] l0, input logic [15:0] l1,
                                       input logic [15:0] l2, input logic [15:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic last, input logic [63:0] xv, input logic [63:0] cv);
        bus.in_valid = v;
        bus.in_last  = last;
        bus.x        = xv;
        bus.c        = cv;
    endtask

    initial begin
        rst_n       = 1'b0;
        clr         = 1'b0;
        bus.o_ready = 1'b1;
        drive(1'b0, 1'b0, '0, '0);
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_o_valid",  64'(bus.o_valid),  64'd0);
        chk("rst_o",        bus.o,             64'd0);
        chk("rst_o_sat",    64'(bus.o_sat),    64'd0);

        // Single beat 1.5*2.0 on every lane
        drive(1'b1, 1'b1, pk(16'h0180, 16'h0180, 16'h0180, 16'h0180),
                          pk(16'h0200, 16'h0200, 16'h0200, 16'h0200));
        tick();
        chk("t1_o_valid", 64'(bus.o_valid), 64'd1);
        chk("t1_o",       bus.o, pk(16'h0300, 16'h0300, 16'h0300, 16'h0300));
        chk("t1_o_sat",   64'(bus.o_sat), 64'd0);

        // Back-to-back single-beat vector, distinct per lane
        drive(1'b1, 1'b1, pk(16'h0180, 16'hFF00, 16'h0080, 16'h0100),
                          pk(16'h0200, 16'h0100, 16'h0080, 16'h7FFF));
        #1;
        chk("b2b_in_ready", 64'(bus.in_ready), 64'd1);
        tick();
        chk("b2b_o_valid", 64'(bus.o_valid), 64'd1);
        chk("b2b_o", bus.o, pk(16'h0300, RELU ? 16'h0000 : 16'hFF00, 16'h0040, 16'h7FFF));
        chk("b2b_o_sat", 64'(bus.o_sat), 64'd0);

        // Output taken with no new beat: o_valid drops, o holds
        drive(1'b0, 1'b0, '0, '0);
        tick();
        chk("drain_o_valid", 64'(bus.o_valid), 64'd0);
        chk("drain_o_hold", bus.o, pk(16'h0300, RELU ? 16'h0000 : 16'hFF00, 16'h0040, 16'h7FFF));

        // Three-beat vector on lane 0: 1.0 + 1.0 - 3.0 = -1.0
        drive(1'b1, 1'b0, pk(16'h0100, 0, 0, 0), pk(16'h0100, 0, 0, 0));
        tick();
        chk("t2_mid_o_valid", 64'(bus.o_valid), 64'd0);
        drive(1'b1, 1'b0, pk(16'h0200, 0, 0, 0), pk(16'h0080, 0, 0, 0));
        tick();
        drive(1'b1, 1'b1, pk(16'hFE80, 0, 0, 0), pk(16'h0200, 0, 0, 0));
        tick();
        chk("t2_o_valid", 64'(bus.o_valid), 64'd1);
        chk("t2_o", bus.o, pk(RELU ? 16'h0000 : 16'hFF00, 0, 0, 0));

        // Rounding: +half rounds up, -half rounds to zero
        drive(1'b1, 1'b1, pk(16'h0001, 16'hFFFF, 0, 0), pk(16'h0080, 16'h0080, 0, 0));
        tick();
        chk("t3_round", bus.o, pk(16'h0001, 16'h0000, 0, 0));
        chk("t3_o_sat", 64'(bus.o_sat), 64'd0);

        // Saturation at both bounds
        drive(1'b1, 1'b1, pk(16'h7F00, 16'h8000, 0, 0), pk(16'h7F00, 16'h7F00, 0, 0));
        tick();
        chk("t4_sat_o", bus.o, pk(16'h7FFF, RELU ? 16'h0000 : 16'h8000, 0, 0));
        chk("t4_sat_flag", 64'(bus.o_sat), RELU ? 64'h1 : 64'h3);

        // Stall: pending result blocks every beat
        bus.o_ready = 1'b0;
        drive(1'b1, 1'b0, pk(16'h0100, 0, 0, 0), pk(16'h0100, 0, 0, 0));
        #1;
        chk("t5_in_ready_low", 64'(bus.in_ready), 64'd0);
        tick();
        chk("t5_hold_valid", 64'(bus.o_valid), 64'd1);
        chk("t5_hold_o", bus.o, pk(16'h7FFF, RELU ? 16'h0000 : 16'h8000, 0, 0));
        tick();
        chk("t5_hold_o2", bus.o, pk(16'h7FFF, RELU ? 16'h0000 : 16'h8000, 0, 0));
        // Release together with a last beat; the blocked beats must not count
        bus.o_ready = 1'b1;
        drive(1'b1, 1'b1, pk(16'h0100, 0, 0, 0), pk(16'h0200, 0, 0, 0));
        #1;
        chk("t5_in_ready_high", 64'(bus.in_ready), 64'd1);
        tick();
        chk("t5_nobubble_valid", 64'(bus.o_valid), 64'd1);
        chk("t5_new_o", bus.o, pk(16'h0200, 0, 0, 0));
        chk("t5_new_sat", 64'(bus.o_sat), 64'd0);

        // clr after two beats; the last beat during clr is dropped
        drive(1'b1, 1'b0, pk(16'h0100, 0, 0, 0), pk(16'h0100, 0, 0, 0));
        tick();
        tick();
        clr = 1'b1;
        drive(1'b1, 1'b1, pk(16'h0100, 0, 0, 0), pk(16'h0300, 0, 0, 0));
        tick();
        clr = 1'b0;
        chk("t6_clr_o_valid", 64'(bus.o_valid), 64'd0);
        chk("t6_clr_o_hold", bus.o, pk(16'h0200, 0, 0, 0));
        drive(1'b1, 1'b1, pk(16'h0100, 0, 0, 0), pk(16'h0100, 0, 0, 0));
        tick();
        chk("t6_after_clr", bus.o, pk(16'h0100, 0, 0, 0));
        chk("t6_valid", 64'(bus.o_valid), 64'd1);

        // Reset with a pending result
        bus.o_ready = 1'b0;
        drive(1'b0, 1'b0, '0, '0);
        rst_n = 1'b0;
        tick();
        chk("t7_rst_o_valid", 64'(bus.o_valid), 64'd0);
        chk("t7_rst_o", bus.o, 64'd0);
        chk("t7_rst_in_ready", 64'(bus.in_ready), 64'd1);
        rst_n = 1'b1;
        bus.o_ready = 1'b1;

        // Reset mid-vector discards the partial sum
        drive(1'b1, 1'b0, pk(16'h0200, 16'h0100, 0, 0), pk(16'h0100, 16'h0100, 0, 0));
        tick();
        drive(1'b0, 1'b0, '0, '0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drive(1'b1, 1'b1, pk(16'h0100, 0, 0, 0), pk(16'h0100, 0, 0, 0));
        tick();
        drive(1'b0, 1'b0, '0, '0);
        chk("t7_fresh_o", bus.o, pk(16'h0100, 0, 0, 0));
        chk("t7_fresh_valid", 64'(bus.o_valid), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
